// File: rtl/rms_ctx_sequencer_if.sv
// Context-sequencer bus: control-unit requests, rms context in/out and data-memory port.
// The slave modport is the sequencer side, the master modport is the surrounding system.
interface rms_ctx_sequencer_if #(
  parameter int WORD_W = 16,
  parameter int NREGS  = 15,
  parameter int ADDR_W = 16
);
  logic                      call_req;
  logic                      ret_req;
  logic [ADDR_W-1:0]         sp_in;
  logic [NREGS*WORD_W-1:0]   ctx_in;
  logic [NREGS*WORD_W-1:0]   ctx_out;
  logic                      restore;
  logic [ADDR_W-1:0]         mem_addr;
  logic [WORD_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic                      mem_re;
  logic [WORD_W-1:0]         mem_rdata;
  logic                      mem_ready;
  logic                      busy;
  logic                      stall;
  logic                      done;
  logic                      err;
  logic                      chk_err;

  modport slave (
    input  call_req, ret_req, sp_in, ctx_in, mem_rdata, mem_ready,
    output ctx_out, restore, mem_addr, mem_wdata, mem_we, mem_re,
           busy, stall, done, err, chk_err
  );

  modport master (
    output call_req, ret_req, sp_in, ctx_in, mem_rdata, mem_ready,
    input  ctx_out, restore, mem_addr, mem_wdata, mem_we, mem_re,
           busy, stall, done, err, chk_err
  );
endinterface

// File: rtl/rms_ctx_sequencer.sv
// Spills/refills the rms function-call context to stack memory one word per beat.
// Optional RMS_CTX_CHECKSUM_EN appends an XOR word to each frame and checks it on restore.
//
// state | meaning
// IDLE  | waiting for call_req / ret_req
// SAVE  | writing shadow words to base+cnt
// LOAD  | reading frame words from base+cnt into shadow
// RDONE | one cycle: ctx_out valid, restore and done pulsed
module rms_ctx_sequencer #(
  parameter int WORD_W = 16,
  parameter int NREGS  = 15,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rms_ctx_sequencer_if.slave   bus
);
  localparam int CNT_W = $clog2(NREGS + 1);
  localparam logic [CNT_W-1:0] NREGS_CNT = CNT_W'(NREGS);
`ifdef RMS_CTX_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NREGS);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NREGS - 1);
`endif

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, RDONE} stateT;

  stateT                    stateQ, stateD;
  logic [CNT_W-1:0]         cntQ;
  logic [ADDR_W-1:0]        baseQ;
  logic [WORD_W-1:0]        shadowQ [0:NREGS-1];
  logic [NREGS*WORD_W-1:0]  ctxOutQ;
  logic [NREGS*WORD_W-1:0]  ctxPack;
  logic                     doneQ;
  logic                     errQ;
  logic                     chkErrQ;
  logic                     memWe, memRe;
  logic                     beat, lastBeat;
  logic [WORD_W-1:0]        saveWord;
  logic [WORD_W-1:0]        xorAll;

  assign beat     = (memWe | memRe) & bus.mem_ready;
  assign lastBeat = beat && (cntQ == LAST_CNT);

  always_comb begin
    xorAll = '0;
    for (int i = 0; i < NREGS; i++) begin
      xorAll = xorAll ^ shadowQ[i];
    end
  end

`ifdef RMS_CTX_CHECKSUM_EN
  assign saveWord = (cntQ == NREGS_CNT) ? xorAll : shadowQ[cntQ];
`else
  assign saveWord = shadowQ[cntQ];
`endif

  // Frame as it will look once the current read beat lands; loaded into ctx_out on entry to RDONE.
  always_comb begin
    ctxPack = '0;
    for (int i = 0; i < NREGS; i++) begin
      ctxPack[i*WORD_W +: WORD_W] = (CNT_W'(i) == cntQ) ? bus.mem_rdata : shadowQ[i];
    end
  end

  always_comb begin
    stateD = stateQ;
    memWe  = 1'b0;
    memRe  = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.call_req)     stateD = SAVE;
        else if (bus.ret_req) stateD = LOAD;
      end
      SAVE: begin
        memWe = 1'b1;
        if (lastBeat) stateD = IDLE;
      end
      LOAD: begin
        memRe = 1'b1;
        if (lastBeat) stateD = RDONE;
      end
      RDONE:   stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      baseQ   <= '0;
      ctxOutQ <= '0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
      chkErrQ <= 1'b0;
      for (int i = 0; i < NREGS; i++) shadowQ[i] <= '0;
    end else begin
      stateQ  <= stateD;
      doneQ   <= 1'b0;
      chkErrQ <= 1'b0;
      // Any request outside IDLE is dropped, as is a ret that collides with a call.
      errQ    <= ((stateQ != IDLE) && (bus.call_req || bus.ret_req)) ||
                 ((stateQ == IDLE) && bus.call_req && bus.ret_req);
      case (stateQ)
        IDLE: begin
          if (bus.call_req || bus.ret_req) begin
            baseQ <= bus.sp_in;
            cntQ  <= '0;
          end
          if (bus.call_req) begin
            for (int i = 0; i < NREGS; i++) shadowQ[i] <= bus.ctx_in[i*WORD_W +: WORD_W];
          end
        end
        SAVE: begin
          if (beat) cntQ <= cntQ + CNT_W'(1);
          if (lastBeat) doneQ <= 1'b1;
        end
        LOAD: begin
          if (beat) begin
            cntQ <= cntQ + CNT_W'(1);
            if (cntQ < NREGS_CNT) shadowQ[cntQ] <= bus.mem_rdata;
          end
          if (lastBeat) begin
            ctxOutQ <= ctxPack;
            chkErrQ <= (xorAll != bus.mem_rdata);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = memWe;
  assign bus.mem_re    = memRe;
  assign bus.mem_addr  = (memWe | memRe) ? (baseQ + ADDR_W'(cntQ)) : '0;
  assign bus.mem_wdata = memWe ? saveWord : '0;
  assign bus.busy      = (stateQ != IDLE);
  assign bus.stall     = (stateQ != IDLE);
  assign bus.restore   = (stateQ == RDONE);
  assign bus.done      = doneQ | (stateQ == RDONE);
  assign bus.err       = errQ;
  assign bus.ctx_out   = ctxOutQ;
`ifdef RMS_CTX_CHECKSUM_EN
  assign bus.chk_err   = chkErrQ & (stateQ == RDONE);
`else
  assign bus.chk_err   = 1'b0;
`endif
endmodule
